// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-encoder arbiter: default sizes and a
// width-generic binary-to-Gray helper.
package gray_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int IDW       = $clog2(NREQ_DEF);
  localparam int GRAY_MAXW = 32;

  // Callers zero-extend to GRAY_MAXW; the low bits of the result are the
  // Gray code of the narrower word, because the extension bits are zero.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: the first asserted request at or after ptr
// wins. The search wraps modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  int unsigned    idx;
  logic [IDW-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = k + 32'(ptr);
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// One binary-to-Gray encoder shared among NREQ requesters through a
// round-robin arbiter and a single registered valid/ready output stage.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_gray,
  output logic [WIDTH-1:0]        out_bin,
  output logic [$clog2(NREQ)-1:0] out_id,
  input  logic                    out_ready
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0]            ptr;
  logic [NREQ-1:0]            grant;
  logic [ID_W-1:0]            win_idx;
  logic                       any_req;
  logic                       load_en;
  logic                       accept;
  logic [WIDTH-1:0]           win_word;
  logic [WIDTH-1:0]           gray_word;
  logic [GRAY_MAXW-1:WIDTH]   gray_unused;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (win_idx),
    .any       (any_req)
  );

  assign load_en   = !out_valid || out_ready;
  assign accept    = any_req && load_en && !rst;
  assign req_ready = accept ? grant : '0;
  assign win_word  = req_data[win_idx*WIDTH +: WIDTH];
  assign {gray_unused, gray_word} = bin2gray(GRAY_MAXW'(win_word));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_gray  <= '0;
      out_bin   <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_gray  <= gray_word;
      out_bin   <= win_word;
      out_id    <= win_idx;
      ptr       <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (out_ready) begin
      // Drain with nothing to load: data holds, only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter (NREQ=4, WIDTH=4).
`timescale 1ns/1ps
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_gray;
  logic [3:0]  out_bin;
  logic [1:0]  out_id;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 16'hF870;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
        fails++; $display("FAIL reset_req_ready got %b exp 0000", req_ready);
      end
      step();
      tests++;
      if (out_valid !== 1'b0 || out_gray !== 4'h0 || out_bin !== 4'h0 || out_id !== 2'd0) begin
        fails++;
        $display("FAIL reset_outputs got v=%b g=%b b=%b id=%0d exp v=0 g=0000 b=0000 id=0",
                 out_valid, out_gray, out_bin, out_id);
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL reset_first_grant got %b exp 0001", req_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      fails++; $display("FAIL reset_first_out got v=%b id=%0d exp v=1 id=0", out_valid, out_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data  = 16'h0600;
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL single_req_ready got %b exp 0100", req_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_gray !== 4'b0101 || out_bin !== 4'b0110 || out_id !== 2'd2) begin
      fails++;
      $display("FAIL single_out got v=%b g=%b b=%b id=%0d exp v=1 g=0101 b=0110 id=2",
               out_valid, out_gray, out_bin, out_id);
    end
    req_valid = 4'b0000;
    step();
    tests++;
    if (out_valid !== 1'b0 || out_bin !== 4'b0110 || out_gray !== 4'b0101) begin
      fails++;
      $display("FAIL drain got v=%b g=%b b=%b exp v=0 g=0101 b=0110", out_valid, out_gray, out_bin);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_gray [4];
    logic [3:0] exp_bin  [4];
    exp_gray = '{4'b0000, 4'b0100, 4'b1100, 4'b1000};
    exp_bin  = '{4'b0000, 4'b0111, 4'b1000, 4'b1111};
    do_reset();
    req_valid = 4'b1111;
    req_data  = 16'hF870;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        fails++; $display("FAIL rotate_ready[%0d] got %b exp %b", k, req_ready, 4'b0001 << (k % 4));
      end
      step();
      tests++;
      if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_gray !== exp_gray[k % 4]
          || out_bin !== exp_bin[k % 4]) begin
        fails++;
        $display("FAIL rotate_out[%0d] got v=%b id=%0d g=%b b=%b exp v=1 id=%0d g=%b b=%b",
                 k, out_valid, out_id, out_gray, out_bin, k % 4, exp_gray[k % 4], exp_bin[k % 4]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b1111;
    req_data  = 16'hF870;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
        fails++; $display("FAIL stall_ready[%0d] got %b exp 0000", c, req_ready);
      end
      step();
      tests++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_bin !== 4'b0111 || out_gray !== 4'b0100) begin
        fails++;
        $display("FAIL stall_hold[%0d] got v=%b id=%0d b=%b g=%b exp v=1 id=1 b=0111 g=0100",
                 c, out_valid, out_id, out_bin, out_gray);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL stall_release_ready got %b exp 0100", req_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_gray !== 4'b1100) begin
      fails++;
      $display("FAIL stall_back_to_back got v=%b id=%0d g=%b exp v=1 id=2 g=1100",
               out_valid, out_id, out_gray);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] b;
    logic [3:0] exp_g;
    logic [3:0] prev_g;
    logic [3:0] diff;
    do_reset();
    req_valid = 4'b0010;
    out_ready = 1'b1;
    prev_g    = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      b        = 4'(v);
      exp_g    = b ^ (b >> 1);
      req_data = {8'h00, b, 4'h0};
      step();
      tests++;
      if (out_valid !== 1'b1 || out_gray !== exp_g || out_bin !== b || out_id !== 2'd1) begin
        fails++;
        $display("FAIL sweep[%0d] got v=%b g=%b b=%b id=%0d exp v=1 g=%b b=%b id=1",
                 v, out_valid, out_gray, out_bin, out_id, exp_g, b);
      end
      if (v > 0) begin
        diff = out_gray ^ prev_g;
        tests++;
        if ($countones(diff) != 1) begin
          fails++; $display("FAIL sweep_onebit[%0d] got diff=%b exp one bit set", v, diff);
        end
      end
      prev_g = out_gray;
    end
    tests++;
    if (out_gray !== 4'b1000) begin
      fails++; $display("FAIL all_ones got %b exp 1000", out_gray);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0001;
    req_data  = 16'h0005;
    out_ready = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b1 || out_bin !== 4'h5) begin
      fails++; $display("FAIL midrst_setup got v=%b b=%b exp v=1 b=0101", out_valid, out_bin);
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL midrst_ready got %b exp 0000", req_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || out_bin !== 4'h0 || out_id !== 2'd0) begin
      fails++;
      $display("FAIL midrst_out got v=%b b=%b id=%0d exp v=0 b=0000 id=0", out_valid, out_bin, out_id);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL midrst_ptr got %b exp 0001", req_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_sweep();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
